// File: rtl/apb_protocol_monitor.sv
// -----------------------------------------------------------------------------
// apb_protocol_monitor
//
// Passive APB checker and transfer monitor. It samples the APB bus on every
// rising pclock edge and never drives it. It tracks the IDLE/SETUP/ACCESS
// phases, flags protocol and X/Z violations, times out stalled slaves and
// publishes one record for each completed transfer. X/Z detection makes this
// a simulation-side component.
//
// Handshake: a transfer completes on an access cycle (psel and penable high,
// control signals stable since setup) in which pready is sampled high.
// Each access cycle with pready low is one wait state.
//
// Ports
//   pclock, preset       bus clock (rising edge), async active-low reset
//   has_checks           0 = suppress err_valid/err_sticky/err_count updates
//   clr_errors           synchronous clear of err_sticky and err_count
//   paddr .. pslverr     sampled APB bus signals
//   err_valid/err_code   pulse plus lowest violation code seen at last edge
//   err_sticky           bit n-1 is set by violation code n
//   err_count            saturating count of cycles with a violation
//   xfer_*               record of the transfer completed at last edge
//   fsm_state            phase tracker state (0 idle, 1 setup, 2 access)
// -----------------------------------------------------------------------------
module apb_protocol_monitor #(
   parameter int PADDR_WIDTH   = 32,
   parameter int PWDATA_WIDTH  = 8,
   parameter int PRDATA_WIDTH  = PWDATA_WIDTH,
   parameter int NUM_SLAVES    = 16,
   parameter int MAX_WAIT      = 16,
   parameter int ERR_CNT_WIDTH = 8,
   localparam int DATA_WIDTH   = (PWDATA_WIDTH > PRDATA_WIDTH) ? PWDATA_WIDTH : PRDATA_WIDTH,
   localparam int WAIT_WIDTH   = $clog2(MAX_WAIT + 1)
) (
   input  logic                     pclock,
   input  logic                     preset,
   input  logic                     has_checks,
   input  logic                     clr_errors,
   input  logic [PADDR_WIDTH-1:0]   paddr,
   input  logic                     prwd,
   input  logic [PWDATA_WIDTH-1:0]  pwdata,
   input  logic                     penable,
   input  logic                     pready,
   input  logic [NUM_SLAVES-1:0]    psel,
   input  logic [PRDATA_WIDTH-1:0]  prdata,
   input  logic                     pslverr,
   output logic                     err_valid,
   output logic [3:0]               err_code,
   output logic [10:0]              err_sticky,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic                     xfer_done,
   output logic                     xfer_write,
   output logic [PADDR_WIDTH-1:0]   xfer_addr,
   output logic [DATA_WIDTH-1:0]    xfer_data,
   output logic                     xfer_slverr,
   output logic [NUM_SLAVES-1:0]    xfer_sel,
   output logic [WAIT_WIDTH-1:0]    xfer_waits,
   output logic [1:0]               fsm_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [WAIT_WIDTH-1:0]   wait_q, wait_d, wait_base;

   // Control captured in the setup cycle; must stay stable through access.
   logic [PADDR_WIDTH-1:0]  lat_addr;
   logic                    lat_write;
   logic [PWDATA_WIDTH-1:0] lat_wdata;
   logic [NUM_SLAVES-1:0]   lat_sel;

   logic [10:0]             viol;
   logic [3:0]              code;
   logic                    ctrl_x, ctrl_match, from_idle, access, complete, load_latch;

   assign fsm_state = state_q;

   // ---------------------------------------------------------------------------
   // Cycle classification and next state
   // ---------------------------------------------------------------------------
   always_comb begin
      viol       = '0;
      state_d    = ST_IDLE;
      wait_d     = '0;
      wait_base  = '0;
      from_idle  = 1'b0;
      access     = 1'b0;
      complete   = 1'b0;
      load_latch = 1'b0;
      ctrl_x     = $isunknown(psel) || $isunknown(penable);
      // Case-equality so an unknown bus value counts as a change rather than
      // propagating X into the decision.
      ctrl_match = (psel === lat_sel) && (paddr === lat_addr) && (prwd === lat_write) &&
                   (!lat_write || (pwdata === lat_wdata));

      if (ctrl_x) begin
         // Phase cannot be trusted: report only the control X/Z and drop to idle.
         viol[3] = $isunknown(penable);
         viol[4] = $isunknown(psel);
      end else begin
         if (psel != '0) begin
            viol[0] = $isunknown(paddr);
            viol[1] = $isunknown(prwd);
            viol[2] = (prwd === 1'b1) && $isunknown(pwdata);
            viol[5] = ($countones(psel) > 1);
         end

         unique case (state_q)
            ST_IDLE: from_idle = 1'b1;
            ST_SETUP: begin
               if (!penable) begin
                  // Setup not followed by access; the cycle may itself start a new setup.
                  viol[8]   = 1'b1;
                  from_idle = 1'b1;
               end else if (ctrl_match) begin
                  access = 1'b1;
               end else begin
                  viol[7] = 1'b1;
               end
            end
            ST_ACCESS: begin
               if (penable && ctrl_match) begin
                  access    = 1'b1;
                  wait_base = wait_q;
               end else begin
                  viol[7] = 1'b1;
               end
            end
            default: from_idle = 1'b1;
         endcase

         if (from_idle && (psel != '0)) begin
            if (penable) begin
               viol[6] = 1'b1;
            end else begin
               load_latch = 1'b1;
               state_d    = ST_SETUP;
            end
         end

         if (access) begin
            if (pready) begin
               complete = 1'b1;
               viol[10] = !lat_write && $isunknown(prdata);
            end else if ((wait_base + WAIT_WIDTH'(1)) == WAIT_WIDTH'(MAX_WAIT)) begin
               viol[9] = 1'b1;
            end else begin
               state_d = ST_ACCESS;
               wait_d  = wait_base + WAIT_WIDTH'(1);
            end
         end
      end

      // Lowest-numbered violation wins.
      code = '0;
      for (int i = 10; i >= 0; i--) begin
         if (viol[i]) code = 4'(i + 1);
      end
   end

   // ---------------------------------------------------------------------------
   // Phase tracker and latched control
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclock or negedge preset) begin
      if (!preset) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         lat_sel   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (load_latch) begin
            lat_addr  <= paddr;
            lat_write <= prwd;
            lat_wdata <= pwdata;
            lat_sel   <= psel;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Error reporting
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclock or negedge preset) begin
      if (!preset) begin
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_sticky <= '0;
         err_count  <= '0;
      end else begin
         err_valid <= has_checks && (viol != '0);
         err_code  <= has_checks ? code : 4'd0;
         // A clear on the same edge as a violation wins for sticky and count.
         if (clr_errors) begin
            err_sticky <= '0;
            err_count  <= '0;
         end else if (has_checks) begin
            err_sticky <= err_sticky | viol;
            if ((viol != '0) && (err_count != '1)) err_count <= err_count + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Completed transfer record
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclock or negedge preset) begin
      if (!preset) begin
         xfer_done   <= 1'b0;
         xfer_write  <= 1'b0;
         xfer_addr   <= '0;
         xfer_data   <= '0;
         xfer_slverr <= 1'b0;
         xfer_sel    <= '0;
         xfer_waits  <= '0;
      end else begin
         xfer_done <= complete;
         if (complete) begin
            xfer_write  <= lat_write;
            xfer_addr   <= lat_addr;
            xfer_data   <= lat_write ? DATA_WIDTH'(lat_wdata) : DATA_WIDTH'(prdata);
            xfer_slverr <= pslverr;
            xfer_sel    <= lat_sel;
            xfer_waits  <= wait_base;
         end
      end
   end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Parametrised, passive APB protocol checker and transfer monitor attached to the APB master interface bundle. Samples all APB bus signals every pclock edge, tracks IDLE/SETUP/ACCESS phase, flags protocol and X/Z violations, times out stalled slaves, and publishes one record per completed transfer. Never drives the bus. Simulation-only (uses X/Z detection); sits beside the master driver and monitor in the APB agent.

## Interface
- PADDR_WIDTH, 32, address width
- PWDATA_WIDTH, 8, write data width
- PRDATA_WIDTH, PWDATA_WIDTH, read data width
- NUM_SLAVES, 16, psel width (1..32)
- MAX_WAIT, 16, max consecutive wait states before timeout (>=1)
- ERR_CNT_WIDTH, 8, error counter width
- pclock  in  1  bus clock, all sampling on rising edge
- preset  in  1  asynchronous, active-low reset
- has_checks  in  1  0 = suppress all error reporting (FSM still tracks)
- clr_errors  in  1  synchronous clear of err_sticky and err_count
- paddr, prwd, pwdata, penable, pready, psel, prdata, pslverr  in  widths per parameters (psel NUM_SLAVES)  sampled APB bus
- err_valid  out  1  one-cycle pulse, >=1 violation at last edge
- err_code  out  4  lowest-numbered violation at last edge
- err_sticky  out  11  bit n-1 set by violation code n
- err_count  out  ERR_CNT_WIDTH  cycles with >=1 violation, saturating
- xfer_done  out  1  one-cycle pulse, transfer completed at last edge
- xfer_write, xfer_addr, xfer_data, xfer_slverr, xfer_sel  out  1/PADDR/max(PWDATA,PRDATA)/1/NUM_SLAVES  completed transfer record
- xfer_waits  out  $clog2(MAX_WAIT+1)  wait states of completed transfer

## Operation
- FSM states: IDLE, SETUP, ACCESS (ACCESS = previous cycle was access with pready low). Each edge classifies the sampled cycle using current state.
- IDLE: psel==0 -> IDLE. psel!=0, penable=0 -> SETUP, latch paddr/prwd/pwdata/psel. psel!=0, penable=1 -> code 7, IDLE.
- SETUP: penable=0 -> code 9, then reclassify cycle as from IDLE. penable=1 with psel/paddr/prwd/(pwdata if write) equal to latch -> access cycle, wait=0; mismatch -> code 8, IDLE.
- ACCESS: penable=0 or any latched signal changed -> code 8, IDLE. Else access cycle.
- Access cycle: pready=1 -> complete, IDLE, record outputs updated (read: xfer_data=prdata; write: latched pwdata), xfer_slverr=pslverr. pready=0 -> wait+1; if wait reaches MAX_WAIT -> code 10, IDLE, no xfer_done; else ACCESS.
- Codes: 1 paddr X/Z with psel!=0; 2 prwd X/Z with psel!=0; 3 pwdata X/Z with psel!=0 and prwd=1; 4 penable X/Z; 5 psel X/Z; 6 more than one psel bit set; 7 enable without setup; 8 control change/enable drop in access; 9 setup not followed by access; 10 wait timeout; 11 prdata X/Z at read completion.
- Any X/Z on psel/penable: codes 4/5 only, FSM -> IDLE.
- has_checks=0: err_valid, err_sticky, err_count updates suppressed; FSM and xfer outputs unaffected.
- err_count increments by 1 per violating cycle regardless of code count; holds at all-ones.
- clr_errors with simultaneous violation: clear wins for that edge's sticky/count; err_valid/err_code still report.

## Timing
- All outputs registered; latency 1 cycle: event sampled at edge N visible after edge N until edge N+1.
- xfer_done, err_valid are single-cycle pulses; back-to-back transfers (SETUP directly after completion) give xfer_done every 2 cycles minimum.
- Reset (async assert, sync release): state IDLE, wait 0, all outputs 0 including err_sticky, err_count, xfer record. Reset mid-transfer abandons it, no xfer_done.
- Timeout exactly at MAX_WAIT-th consecutive low pready; pready=1 on that same edge counts as completion with xfer_waits=MAX_WAIT-1.

## Test plan
- Write paddr=0x10, pwdata=0xA5, psel=0x0001, 2 wait states -> xfer_done 1 cycle after pready edge, xfer_write=1, xfer_data=0xA5, xfer_waits=2, no errors.
- Read with prdata=0x3C, pslverr=1, zero wait -> xfer_data=0x3C, xfer_slverr=1, xfer_waits=0.
- psel=0x0003 in setup -> err_code=6, err_sticky[5]=1, err_count=1; penable from IDLE -> err_code=7.
- paddr changed mid-access (pready low) -> err_code=8, no xfer_done; next clean transfer completes normally.
- pready held low MAX_WAIT=4 cycles -> err_code=10 on 4th wait edge; pready on 4th edge instead -> xfer_waits=3, no error.
- 300 violating cycles with ERR_CNT_WIDTH=8 -> err_count=255; clr_errors -> 0; has_checks=0 with pwdata=X write -> no err_valid; preset low mid-access -> all outputs 0.
